// File: rtl/flappy_engine_param.sv
// Flappy game core: bird physics, scrolling LFSR-gapped pipe, collision, BCD score,
// per-column LED matrix scan and two 7-segment digit codes.
module flappy_engine_param #(
  parameter int unsigned N          = 8,
  parameter int unsigned BIRD_COL   = 1,
  parameter int unsigned FALL_TICKS = 50,
  parameter int unsigned PIPE_TICKS = 40,
  parameter int unsigned GAP        = 3,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         jump,
  output logic [N-1:0] row,
  output logic [N-1:0] col,
  output logic [7:0]   tens,
  output logic [7:0]   units,
  output logic [1:0]   state,
  output logic         gameover
);

  localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW      = IW + 1;
  localparam int unsigned FW      = $clog2(FALL_TICKS + 1);
  localparam int unsigned PW      = $clog2(PIPE_TICKS + 1);
  localparam int unsigned GAP_MOD = N - GAP + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  bird_q, bird_d;
  logic [IW-1:0]  pipe_q, pipe_d;
  logic [IW-1:0]  gap_q, gap_d;
  logic [IW-1:0]  scan_q, scan_d;
  logic [3:0]     sc_t_q, sc_t_d;
  logic [3:0]     sc_u_q, sc_u_d;
  logic [FW-1:0]  fall_q, fall_d;
  logic [PW-1:0]  pcnt_q, pcnt_d;
  logic [7:0]     lfsr_q, lfsr_d;
  logic           jump_q;

  logic           jump_rise;
  logic           fall_tick, pipe_tick, go_over, passed;
  logic [IW-1:0]  lift;
  logic [N-1:0]   frame, bird_bit, pipe_bits, col_c;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  assign jump_rise = jump & ~jump_q;
  assign lift      = (bird_q == '0) ? '0 : bird_q - IW'(1);
  assign state     = state_q;

  // Display frame for the column currently being scanned
  always_comb begin
    frame    = '0;
    bird_bit = '0;
    bird_bit[bird_q] = 1'b1;
    col_c    = '0;
    col_c[scan_q] = 1'b1;
    for (int i = 0; i < int'(N); i++)
      pipe_bits[i] = !((i >= int'(gap_q)) && (i < int'(gap_q) + int'(GAP)));
    unique case (state_q)
      S_IDLE: if (scan_q == IW'(BIRD_COL)) frame = bird_bit;
      S_PLAY: begin
        if (scan_q == pipe_q)          frame = pipe_bits;
        if (scan_q == IW'(BIRD_COL))   frame = frame | bird_bit;
      end
      S_OVER: begin
        frame[scan_q]               = 1'b1;
        frame[IW'(N - 1) - scan_q]  = 1'b1;
      end
      default: frame = '0;
    endcase
  end

  // Next-state: game FSM, physics, pipe, score
  always_comb begin
    state_d   = state_q;
    bird_d    = bird_q;
    pipe_d    = pipe_q;
    gap_d     = gap_q;
    sc_t_d    = sc_t_q;
    sc_u_d    = sc_u_q;
    fall_d    = fall_q;
    pcnt_d    = pcnt_q;
    fall_tick = 1'b0;
    pipe_tick = 1'b0;
    go_over   = 1'b0;
    passed    = 1'b0;
    lfsr_d    = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    scan_d    = (scan_q == IW'(N - 1)) ? '0 : scan_q + IW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (jump_rise) begin
          state_d = S_PLAY;
          bird_d  = lift;
          fall_d  = '0;
          pcnt_d  = '0;
        end
      end
      S_PLAY: begin
        fall_tick = (fall_q == FW'(FALL_TICKS - 1));
        fall_d    = fall_tick ? '0 : fall_q + FW'(1);
        pipe_tick = (pcnt_q == PW'(PIPE_TICKS - 1));
        pcnt_d    = pipe_tick ? '0 : pcnt_q + PW'(1);

        // A jump edge overrides a coincident fall tick
        if (jump_rise) begin
          bird_d = lift;
          fall_d = '0;
        end else if (fall_tick) begin
          if (bird_q == IW'(N - 1)) go_over = 1'b1;
          else                      bird_d  = bird_q + IW'(1);
        end

        if (pipe_tick) begin
          if (pipe_q != '0) begin
            pipe_d = pipe_q - IW'(1);
            if (pipe_d == IW'(BIRD_COL)) begin
              if ((bird_d >= gap_q) &&
                  (CW'(bird_d) <= CW'(gap_q) + CW'(GAP - 1))) passed  = 1'b1;
              else                                           go_over = 1'b1;
            end
          end else begin
            pipe_d = IW'(N - 1);
            gap_d  = IW'(lfsr_q % 8'(GAP_MOD));
          end
        end

        if (go_over) begin
          state_d = S_OVER;
        end else if (passed && !(sc_t_q == 4'd9 && sc_u_q == 4'd9)) begin
          if (sc_u_q == 4'd9) begin
            sc_u_d = 4'd0;
            sc_t_d = sc_t_q + 4'd1;
          end else begin
            sc_u_d = sc_u_q + 4'd1;
          end
        end
      end
      S_OVER: begin
        if (jump_rise) begin
          state_d = S_IDLE;
          bird_d  = IW'(N / 2);
          pipe_d  = IW'(N - 1);
          sc_t_d  = 4'd0;
          sc_u_d  = 4'd0;
          fall_d  = '0;
          pcnt_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      bird_q   <= IW'(N / 2);
      pipe_q   <= IW'(N - 1);
      gap_q    <= '0;
      scan_q   <= '0;
      sc_t_q   <= 4'd0;
      sc_u_q   <= 4'd0;
      fall_q   <= '0;
      pcnt_q   <= '0;
      lfsr_q   <= LFSR_SEED;
      jump_q   <= 1'b0;
      row      <= '0;
      col      <= '0;
      tens     <= 8'hC0;
      units    <= 8'hC0;
      gameover <= 1'b0;
    end else begin
      state_q  <= state_d;
      bird_q   <= bird_d;
      pipe_q   <= pipe_d;
      gap_q    <= gap_d;
      scan_q   <= scan_d;
      sc_t_q   <= sc_t_d;
      sc_u_q   <= sc_u_d;
      fall_q   <= fall_d;
      pcnt_q   <= pcnt_d;
      lfsr_q   <= lfsr_d;
      jump_q   <= jump;
      row      <= frame;
      col      <= col_c;
      tens     <= seg7(sc_t_q);
      units    <= seg7(sc_u_q);
      gameover <= (state_d == S_OVER);
    end
  end

endmodule

// File: tb/tb_flappy_engine_param.sv
// Scoreboard bench for flappy_engine_param: an integer game model queues the expected
// outputs for every clock; a negedge monitor pops and compares them.
module tb_flappy_engine_param;

  localparam int N  = 8;
  localparam int BC = 1;
  localparam int FT = 4;
  localparam int PT = 3;
  localparam int G  = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         jump = 1'b0;
  logic [N-1:0] row, col;
  logic [7:0]   tens, units;
  logic [1:0]   state;
  logic         gameover;

  flappy_engine_param #(
    .N(N), .BIRD_COL(BC), .FALL_TICKS(FT), .PIPE_TICKS(PT), .GAP(G), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .jump(jump), .row(row), .col(col),
    .tens(tens), .units(units), .state(state), .gameover(gameover)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] row;
    logic [N-1:0] col;
    logic [7:0]   tens;
    logic [7:0]   units;
    logic [1:0]   st;
    logic         go;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] SEG [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Game model: 0=IDLE 1=PLAY 2=OVER, score as a plain integer
  int         m_state, m_bird, m_pipe, m_gap, m_score, m_fc, m_pc, m_scan;
  bit         m_jq;
  logic [7:0] m_lfsr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_bird = N / 2; m_pipe = N - 1; m_gap = 0; m_score = 0;
    m_fc = 0; m_pc = 0; m_scan = 0; m_jq = 1'b0; m_lfsr = 8'hA5;
  endtask

  function automatic logic [N-1:0] model_frame();
    logic [N-1:0] f;
    f = '0;
    if (m_state == 0) begin
      if (m_scan == BC) f[m_bird] = 1'b1;
    end else if (m_state == 1) begin
      if (m_scan == m_pipe)
        for (int r = 0; r < N; r++)
          if (r < m_gap || r >= m_gap + G) f[r] = 1'b1;
      if (m_scan == BC) f[m_bird] = 1'b1;
    end else begin
      f[m_scan] = 1'b1;
      f[N - 1 - m_scan] = 1'b1;
    end
    return f;
  endfunction

  // One clock of the game, pushing what the DUT must show after that edge
  task automatic model_step(input bit j);
    exp_t e;
    bit   rise, ft, pt, over, pass;
    rise    = j && !m_jq;
    e.row   = model_frame();
    e.col   = '0;
    e.col[m_scan] = 1'b1;
    e.tens  = SEG[m_score / 10];
    e.units = SEG[m_score % 10];
    over = 0; pass = 0;
    if (m_state == 0) begin
      if (rise) begin
        m_state = 1; m_bird = (m_bird > 0) ? m_bird - 1 : 0; m_fc = 0; m_pc = 0;
      end
    end else if (m_state == 1) begin
      ft   = (m_fc == FT - 1);
      pt   = (m_pc == PT - 1);
      m_fc = ft ? 0 : m_fc + 1;
      m_pc = pt ? 0 : m_pc + 1;
      if (rise) begin
        m_bird = (m_bird > 0) ? m_bird - 1 : 0;
        m_fc   = 0;
      end else if (ft) begin
        if (m_bird == N - 1) over = 1;
        else m_bird++;
      end
      if (pt) begin
        if (m_pipe > 0) begin
          m_pipe--;
          if (m_pipe == BC) begin
            if (m_bird >= m_gap && m_bird < m_gap + G) pass = 1;
            else over = 1;
          end
        end else begin
          m_pipe = N - 1;
          m_gap  = int'(m_lfsr) % (N - G + 1);
        end
      end
      if (over) m_state = 2;
      else if (pass && m_score < 99) m_score++;
    end else begin
      if (rise) begin
        m_state = 0; m_bird = N / 2; m_pipe = N - 1; m_score = 0; m_fc = 0; m_pc = 0;
      end
    end
    e.st = 2'(m_state);
    e.go = (m_state == 2);
    q.push_back(e);
    m_lfsr = {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
    m_jq   = j;
    m_scan = (m_scan + 1) % N;
  endtask

  // Called at negedge+1: drive jump, queue expectation, move to the next negedge+1
  task automatic cycle(input bit j);
    jump = j;
    model_step(j);
    @(negedge clk);
    #1;
  endtask

  function automatic bit autopilot();
    if (m_state != 1) return !m_jq;
    return !m_jq && (m_bird >= m_gap + G - 1);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("row",      32'(row),      32'(e.row));
      check("col",      32'(col),      32'(e.col));
      check("tens",     32'(tens),     32'(e.tens));
      check("units",    32'(units),    32'(e.units));
      check("state",    32'(state),    32'(e.st));
      check("gameover", 32'(gameover), 32'(e.go));
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_row"},   32'(row),      32'h0);
    check({tag, "_col"},   32'(col),      32'h0);
    check({tag, "_tens"},  32'(tens),     32'hC0);
    check({tag, "_units"}, 32'(units),    32'hC0);
    check({tag, "_state"}, 32'(state),    32'h0);
    check({tag, "_go"},    32'(gameover), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  budget;
    bit  seen;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    #1 rst_n = 1'b1;

    // Idle with no jumps
    repeat (100) cycle(1'b0);
    check("idle_state", 32'(state), 32'h0);
    check("idle_units", 32'(units), 32'hC0);

    // One jump starts play, then fall until the game ends
    cycle(1'b1);
    check("start_state", 32'(state), 32'h1);
    budget = 0;
    while (m_state != 2 && budget < 200) begin
      cycle(1'b0);
      budget++;
    end
    check("over_reached", 32'(gameover), 32'h1);
    seen = 0;
    for (int k = 0; k < N + 1 && !seen; k++) begin
      if (col == 8'h01) begin
        check("over_x_row", 32'(row), 32'h81);
        seen = 1;
      end else begin
        cycle(1'b0);
      end
    end
    if (!seen) check("over_scan_timeout", 32'(col), 32'h01);

    // Jump in OVER returns to IDLE, never straight to PLAY
    cycle(1'b1);
    check("over_to_idle", 32'(state), 32'h0);
    cycle(1'b0);
    check("idle_units_clr", 32'(units), 32'hC0);

    // Random jumping across all states
    repeat (1500) cycle($urandom_range(0, 3) == 0);

    // Gap-tracking play to build up (and saturate) the score
    repeat (3000) cycle(autopilot());
    if (m_score == 99) begin
      check("sat_tens",  32'(tens),  32'h90);
      check("sat_units", 32'(units), 32'h90);
    end

    // Asynchronous reset in the middle of play
    budget = 0;
    while (m_state != 1 && budget < 50) begin
      cycle(autopilot());
      budget++;
    end
    check("pre_reset_play", 32'(state), 32'h1);
    repeat (7) cycle(autopilot());
    rst_n = 1'b0;
    #2;
    check_reset_values("async");
    model_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (300) cycle($urandom_range(0, 4) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
